// File: rtl/adaptive_walk_filter_if.sv
// Event/bias bundle between the phase detector side and the random-walk loop filter.
// Events are single-cycle level strobes; there is no back-pressure, so no valid/ready pair.
interface adaptive_walk_filter_if #(
    parameter int BW = 4
);
    logic                 forwarding_i;
    logic                 slowing_i;
    logic                 hold_i;
    logic                 bias_load_i;
    logic signed [BW-1:0] bias_value_i;
    logic                 positiveShift_o;
    logic                 negativeShift_o;
    logic signed [BW-1:0] bias_o;
    logic                 lock_o;

    modport master (
        output forwarding_i, slowing_i, hold_i, bias_load_i, bias_value_i,
        input  positiveShift_o, negativeShift_o, bias_o, lock_o
    );

    modport slave (
        input  forwarding_i, slowing_i, hold_i, bias_load_i, bias_value_i,
        output positiveShift_o, negativeShift_o, bias_o, lock_o
    );
endinterface

// File: rtl/adaptive_walk_filter.sv
// Two-level random-walk loop filter: inner counter emits DCO shift pulses and restarts from
// an adaptive bias that an outer, slower counter nudges toward a persistent frequency offset.
module adaptive_walk_filter #(
    parameter int N_MAX       = 8,
    parameter int M_MAX       = 32,
    parameter int BIAS_MAX    = 4,
    parameter int LOCK_CYCLES = 256,
    parameter int BW          = $clog2(N_MAX) + 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    adaptive_walk_filter_if.slave bus
);
    localparam int MW = $clog2(M_MAX) + 1;
    localparam int TW = $clog2(LOCK_CYCLES + 1);

    localparam logic signed [BW-1:0] N_HI    = BW'(N_MAX - 1);
    localparam logic signed [BW-1:0] N_LO    = -N_HI;
    localparam logic signed [BW-1:0] BIAS_HI = BW'(BIAS_MAX);
    localparam logic signed [BW-1:0] BIAS_LO = -BIAS_HI;
    localparam logic signed [BW-1:0] ONE_N   = BW'(1);
    localparam logic signed [MW-1:0] M_HI    = MW'(M_MAX - 1);
    localparam logic signed [MW-1:0] M_LO    = -M_HI;
    localparam logic signed [MW-1:0] ONE_M   = MW'(1);
    localparam logic [TW-1:0]        LOCK_MAX = TW'(LOCK_CYCLES);

    logic signed [BW-1:0] r_n;
    logic signed [MW-1:0] r_m;
    logic signed [BW-1:0] r_bias;
    logic [TW-1:0]        r_timer;
    logic                 r_pos;
    logic                 r_neg;
    logic                 r_lock;

    logic                 w_up;
    logic                 w_dn;
    logic signed [BW-1:0] w_n_step;
    logic signed [MW-1:0] w_m_step;
    logic signed [BW-1:0] w_n_next;
    logic signed [MW-1:0] w_m_next;
    logic signed [BW-1:0] w_bias_next;
    logic signed [BW-1:0] w_load_val;
    logic [TW-1:0]        w_timer_next;
    logic                 w_pos_next;
    logic                 w_neg_next;

    // Opposing strobes in the same cycle cancel.
    assign w_up = bus.forwarding_i & ~bus.slowing_i;
    assign w_dn = bus.slowing_i & ~bus.forwarding_i;

    always_comb begin
        w_load_val = bus.bias_value_i;
        if (bus.bias_value_i > BIAS_HI) begin
            w_load_val = BIAS_HI;
        end else if (bus.bias_value_i < BIAS_LO) begin
            w_load_val = BIAS_LO;
        end
    end

    // A step that lands on +/-threshold fires and restarts instead of being stored.
    always_comb begin
        w_n_step    = r_n;
        w_m_step    = r_m;
        w_n_next    = r_n;
        w_m_next    = r_m;
        w_bias_next = r_bias;
        w_pos_next  = 1'b0;
        w_neg_next  = 1'b0;
        if (w_up) begin
            w_n_step = r_n + ONE_N;
            w_m_step = r_m + ONE_M;
        end else if (w_dn) begin
            w_n_step = r_n - ONE_N;
            w_m_step = r_m - ONE_M;
        end
        w_n_next = w_n_step;
        w_m_next = w_m_step;
        if (w_up && (w_n_step == N_HI)) begin
            w_pos_next = 1'b1;
            w_n_next   = r_bias;
        end else if (w_dn && (w_n_step == N_LO)) begin
            w_neg_next = 1'b1;
            w_n_next   = r_bias;
        end
        if (w_up && (w_m_step == M_HI)) begin
            w_m_next = '0;
            if (r_bias != BIAS_HI) begin
                w_bias_next = r_bias + ONE_N;
            end
        end else if (w_dn && (w_m_step == M_LO)) begin
            w_m_next = '0;
            if (r_bias != BIAS_LO) begin
                w_bias_next = r_bias - ONE_N;
            end
        end
        if (bus.bias_load_i) begin
            w_bias_next = w_load_val;
        end
    end

    always_comb begin
        w_timer_next = r_timer;
        if (w_pos_next || w_neg_next) begin
            w_timer_next = '0;
        end else if (r_timer != LOCK_MAX) begin
            w_timer_next = r_timer + TW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_n     <= '0;
            r_m     <= '0;
            r_bias  <= '0;
            r_timer <= '0;
            r_pos   <= 1'b0;
            r_neg   <= 1'b0;
            r_lock  <= 1'b0;
        end else if (bus.hold_i) begin
            r_pos <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            r_n     <= w_n_next;
            r_m     <= w_m_next;
            r_bias  <= w_bias_next;
            r_timer <= w_timer_next;
            r_pos   <= w_pos_next;
            r_neg   <= w_neg_next;
            r_lock  <= (w_timer_next == LOCK_MAX);
        end
    end

    assign bus.positiveShift_o = r_pos;
    assign bus.negativeShift_o = r_neg;
    assign bus.bias_o          = r_bias;
    assign bus.lock_o          = r_lock;
endmodule

// File: tb/tb_adaptive_walk_filter.sv
// Directed bench for adaptive_walk_filter: lead/lag bursts, bias adaptation and saturation,
// bias load/clamp, hold, lock timer and mid-burst reset, each against hand-computed values.
module tb_adaptive_walk_filter;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adaptive_walk_filter_if #(.BW(BW)) bus ();

    adaptive_walk_filter dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          pos_cnt;
    int          neg_cnt;
    int          both_cnt;
    int          last_pos;
    int          last_neg;
    int          min_bias;
    int          bias_now;
    logic [63:0] pos_mask;

    task automatic check(input string tag, input int got, input int exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.forwarding_i = 1'b0;
        bus.slowing_i    = 1'b0;
        bus.hold_i       = 1'b0;
        bus.bias_load_i  = 1'b0;
        bus.bias_value_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
    endtask

    // Apply 'count' cycles of the given strobes; a pulse seen after cycle i belongs to event i.
    task automatic run(input logic f, input logic s, input int count);
        pos_cnt  = 0;
        neg_cnt  = 0;
        both_cnt = 0;
        last_pos = 0;
        last_neg = 0;
        min_bias = 100;
        pos_mask = '0;
        bus.forwarding_i = f;
        bus.slowing_i    = s;
        for (int i = 1; i <= count; i++) begin
            step();
            bias_now = bus.bias_o;
            if (bias_now < min_bias) min_bias = bias_now;
            if (bus.positiveShift_o) begin
                pos_cnt++;
                last_pos = i;
                if (i < 64) pos_mask[i] = 1'b1;
            end
            if (bus.negativeShift_o) begin
                neg_cnt++;
                last_neg = i;
            end
            if (bus.positiveShift_o && bus.negativeShift_o) both_cnt++;
        end
        bus.forwarding_i = 1'b0;
        bus.slowing_i    = 1'b0;
    endtask

    task automatic load(input logic signed [BW-1:0] v, input logic h);
        bus.bias_load_i  = 1'b1;
        bus.bias_value_i = v;
        bus.hold_i       = h;
        step();
        bus.bias_load_i  = 1'b0;
        bus.bias_value_i = '0;
        bus.hold_i       = 1'b0;
    endtask

    initial begin
        logic [63:0] exp_mask;

        // 1: reset state, then a single 7-lead pulse
        do_reset();
        check("rst_pos", int'(bus.positiveShift_o), 0);
        check("rst_neg", int'(bus.negativeShift_o), 0);
        check("rst_bias", int'(bus.bias_o), 0);
        check("rst_lock", int'(bus.lock_o), 0);
        run(1'b1, 1'b0, 7);
        check("t1_pos_cnt", pos_cnt, 1);
        check("t1_pos_idx", last_pos, 7);
        check("t1_neg_cnt", neg_cnt, 0);
        run(1'b0, 1'b0, 1);
        check("t1_pos_drop", int'(bus.positiveShift_o), 0);
        check("t1_bias", int'(bus.bias_o), 0);
        run(1'b1, 1'b0, 7);
        check("t1_n_zero", last_pos, 7);

        // 2: outer overflow raises bias, inner restarts from bias
        do_reset();
        run(1'b1, 1'b0, 30);
        exp_mask = '0;
        exp_mask[7] = 1'b1; exp_mask[14] = 1'b1; exp_mask[21] = 1'b1; exp_mask[28] = 1'b1;
        check("t2_mask_lo", int'(pos_mask[31:0]), int'(exp_mask[31:0]));
        check("t2_bias30", int'(bus.bias_o), 0);
        run(1'b1, 1'b0, 1);
        check("t2_bias31", int'(bus.bias_o), 1);
        run(1'b1, 1'b0, 4);
        check("t2_pulse35", last_pos, 4);
        run(1'b1, 1'b0, 6);
        check("t2_pulse41_cnt", pos_cnt, 1);
        check("t2_pulse41_idx", last_pos, 6);

        // 3: long lag burst, bias saturates at -4
        do_reset();
        run(1'b0, 1'b1, 200);
        check("t3_neg_cnt", neg_cnt, 48);
        check("t3_pos_cnt", pos_cnt, 0);
        check("t3_both", both_cnt, 0);
        check("t3_min_bias", min_bias, -4);
        check("t3_bias", int'(bus.bias_o), -4);
        check("t3_last_neg", last_neg, 199);

        // 4: cancelled events, lock timer
        do_reset();
        run(1'b1, 1'b1, 255);
        check("t4_lock255", int'(bus.lock_o), 0);
        check("t4_pulses_a", pos_cnt + neg_cnt, 0);
        run(1'b1, 1'b1, 1);
        check("t4_lock256", int'(bus.lock_o), 1);
        run(1'b1, 1'b1, 44);
        check("t4_lock300", int'(bus.lock_o), 1);
        check("t4_pulses_b", pos_cnt + neg_cnt, 0);
        check("t4_bias", int'(bus.bias_o), 0);
        run(1'b1, 1'b0, 6);
        check("t4_lock_pre", int'(bus.lock_o), 1);
        run(1'b1, 1'b0, 1);
        check("t4_pulse", int'(bus.positiveShift_o), 1);
        check("t4_lock_clr", int'(bus.lock_o), 0);

        // 5: bias load clamp, hold, reload from loaded bias
        do_reset();
        load(-4'sd8, 1'b0);
        check("t5_clamp_neg", int'(bus.bias_o), -4);
        load(4'sd7, 1'b0);
        check("t5_clamp_pos", int'(bus.bias_o), 4);
        load(4'sd3, 1'b0);
        check("t5_load3", int'(bus.bias_o), 3);
        load(-4'sd2, 1'b1);
        check("t5_hold_load", int'(bus.bias_o), 3);
        run(1'b1, 1'b0, 7);
        check("t5_first_pulse", last_pos, 7);
        run(1'b1, 1'b0, 4);
        check("t5_reload_cnt", pos_cnt, 1);
        check("t5_reload_idx", last_pos, 4);
        run(1'b1, 1'b0, 3);
        check("t5_pre_hold", pos_cnt, 0);
        bus.hold_i = 1'b1;
        run(1'b1, 1'b0, 3);
        bus.hold_i = 1'b0;
        check("t5_hold_pulses", pos_cnt, 0);
        check("t5_hold_bias", int'(bus.bias_o), 3);
        run(1'b1, 1'b0, 1);
        check("t5_after_hold", pos_cnt, 1);

        // load wins over a same-cycle outer overflow
        do_reset();
        run(1'b1, 1'b0, 30);
        bus.forwarding_i = 1'b1;
        load(4'sd3, 1'b0);
        bus.forwarding_i = 1'b0;
        check("t5_load_over_ovf", int'(bus.bias_o), 3);

        // 6: reset mid-burst with n=6, bias=2
        do_reset();
        load(4'sd2, 1'b0);
        run(1'b1, 1'b0, 6);
        check("t6_pre_cnt", pos_cnt, 0);
        check("t6_pre_bias", int'(bus.bias_o), 2);
        rst = 1'b1;
        bus.forwarding_i = 1'b1;
        step();
        rst = 1'b0;
        bus.forwarding_i = 1'b0;
        check("t6_rst_pos", int'(bus.positiveShift_o), 0);
        check("t6_rst_bias", int'(bus.bias_o), 0);
        check("t6_rst_lock", int'(bus.lock_o), 0);
        run(1'b1, 1'b0, 6);
        check("t6_post_6", pos_cnt, 0);
        run(1'b1, 1'b0, 1);
        check("t6_post_7", pos_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
